ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs (operand register data and decoded EX control). It executes MULT/MULTU/DIV/DIVU over multiple cycles into private HI/LO registers and services MTHI/MTLO. It raises a stall request so the hazard logic holds ID/EX while an HI/LO access collides with an operation in flight.

## Interface
- No parameters. Iteration count is fixed at 32 and defined in the package.
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  ID/EX presents a mul/div op this cycle.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  in  32  multiplicand/dividend (ID/EX Reg_RData1 path).
- rt_data  in  32  multiplier/divisor (ID/EX Reg_RData2 path).
- mthi, mtlo  in  1  write rs_data into HI / LO.
- hilo_rd  in  1  MFHI/MFLO in EX this cycle.
- cancel  in  1  pipeline flush; aborts the op in flight.
- hi, lo  out  32  architectural HI/LO registers.
- busy  out  1  high when state is not IDLE.
- stall_req  out  1  combinational: busy & (start | mthi | mtlo | hilo_rd).
- done  out  1  one-cycle pulse on the cycle HI/LO take a result.

## Operation
- States: IDLE, CALC, FIX.
- IDLE and start=1: latch |rs|, |rt| (signed ops) or raw values (unsigned ops); latch result sign (MULT: rs[31]^rt[31]; DIV: quotient sign rs[31]^rt[31], remainder sign rs[31]); counter=31; go to CALC.
- Multiply in CALC: radix-2 shift-add into 64-bit accumulator, one multiplier bit per cycle, LSB first.
- Divide in CALC: restoring, one quotient bit per cycle, MSB first, 33-bit partial remainder.
- CALC with counter=0 goes to FIX; otherwise counter decrements.
- FIX: negate per latched signs, write HI/LO, pulse done, go to IDLE.
- Divide by zero: LO=32'hFFFFFFFF, HI=rs_data as latched (raw, unsigned and signed alike). Normal latency.
- DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
- mthi/mtlo in IDLE: write on the next edge. Simultaneous with start: the start takes priority and the mthi/mtlo is dropped.
- start, mthi, mtlo while busy: ignored. stall_req holds them in ID/EX until IDLE.
- cancel: any state goes to IDLE on the next edge; HI/LO unchanged; no done. cancel together with start in IDLE: start is ignored.
- reset asserted at any time: immediately IDLE, hi=lo=0, busy=0, done=0, counter=0.

## Timing
- Start accepted at edge E0. CALC iterations occur at E1..E32. FIX occurs at E33, where HI/LO are written and done goes high for the cycle after E33.
- busy is high from after E0 through the cycle before E33 completes, and low after E33.
- A result is readable by an MFHI/MFLO issued in the cycle after E33. The same-cycle read while busy stalls.
- stall_req has no register delay and is valid in the same cycle as its inputs.

## Configuration
- MULDIV_EARLY_OUT_EN defined: a multiply leaves CALC for FIX after the iteration in which the remaining multiplier bits become zero.
  - A multiplier of zero at accept goes straight to FIX at E1.
  - Divide latency is unchanged.
- Undefined: fixed 34-edge latency for all ops.

## Structure
- Shared package muldiv_pkg holds:
  - the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum (IDLE, CALC, FIX);
  - the constant MULDIV_ITERS=32.
- One sub-module, muldiv_signfix: combinational conditional two's-complement negation of the 64-bit {HI,LO} result, used in FIX.

## Test plan
- MULT rs=-3 (32'hFFFFFFFD), rt=5 -> after 34 edges, done pulse; HI=32'hFFFFFFFF, LO=32'hFFFFFFF1.
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
- DIV rs=-7, rt=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1); DIVU 7/0 -> LO=32'hFFFFFFFF, HI=7.
- Start DIVU 100/7, then assert hilo_rd at E5 -> stall_req=1 until E33; after E33, LO=14, HI=2, stall_req=0.
- Start MULT, assert cancel at E10 -> IDLE at E11; HI/LO keep prior values (seed via mthi=32'hA5A5A5A5); done never pulses.
- Drop reset low at E15 of a DIV -> hi=lo=0, busy=0 immediately. Early-out build: MULTU 9×3 -> done after E3 (2-bit multiplier), HI=0, LO=27.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the EX-stage multiply/divide unit.
// Holds the op encodings, the FSM state type, the iteration count and a
// magnitude helper used when latching signed operands.
package muldiv_pkg;

  localparam int MULDIV_ITERS = 32;
  localparam int CNT_W        = $clog2(MULDIV_ITERS);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULDIV_ITERS - 1);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Magnitude of a 32-bit operand; unsigned ops pass the raw value through.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: conditional two's-complement negation of the {HI,LO}
// result. A multiply negates the full 64-bit product; a divide negates the
// remainder (HI) and quotient (LO) halves independently.
module muldiv_signfix (
  input  logic [63:0] i_data,
  input  logic        i_neg_full,
  input  logic        i_neg_hi,
  input  logic        i_neg_lo,
  output logic [63:0] o_data
);

  // Select full-width or per-half negation of the raw magnitude result.
  always_comb begin
    // NOTE: default assignment first so every path drives o_data and no latch is inferred.
    o_data = i_data;
    if (i_neg_full) begin
      o_data = ~i_data + 64'd1;
    end else begin
      if (i_neg_hi) o_data[63:32] = ~i_data[63:32] + 32'd1;
      if (i_neg_lo) o_data[31:0]  = ~i_data[31:0]  + 32'd1;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit with private HI/LO.
// One operand bit per CALC cycle (shift-add multiply, restoring divide),
// then a FIX cycle applies signs and writes HI/LO. A combinational stall
// request holds ID/EX while a HI/LO access meets an op in flight.
// Optional macro MULDIV_EARLY_OUT_EN: a multiply leaves CALC as soon as the
// remaining multiplier bits are all zero (divide latency unchanged).
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        hilo_rd,
  input  logic        cancel,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_req,
  output logic        done
);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;

  logic               r_is_div;
  logic               r_divz;
  logic               r_neg_q;    // product sign (mul) or quotient sign (div)
  logic               r_neg_r;    // remainder sign (div only)
  logic [31:0]        r_rs_raw;   // raw dividend, reported in HI on divide by zero

  logic [63:0]        r_mcand;    // multiplicand, shifted left each iteration
  logic [31:0]        r_mplier;   // multiplier, shifted right each iteration
  logic [63:0]        r_acc;

  logic [31:0]        r_quot;     // dividend bits shift out MSB-first, quotient bits shift in
  logic [31:0]        r_rem;
  logic [31:0]        r_divisor;

  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic               r_done;

  logic               w_accept;
  logic               w_in_calc;
  logic               w_in_fix;
  logic               w_early_out;
  logic               w_signed;
  logic [31:0]        w_a_mag;
  logic [31:0]        w_b_mag;
  logic [63:0]        w_acc_nxt;
  logic [32:0]        w_rem_sh;
  logic [31:0]        w_rem_diff;
  logic               w_q_bit;
  logic [63:0]        w_raw_result;
  logic [63:0]        w_fixed_result;
  logic [63:0]        w_result;

  assign w_accept  = (r_state == IDLE) & start & ~cancel;
  assign w_signed  = ~op[0];
  assign w_a_mag   = mag32(rs_data, w_signed);
  assign w_b_mag   = mag32(rt_data, w_signed);

`ifdef MULDIV_EARLY_OUT_EN
  assign w_early_out = ~r_is_div & (r_mplier[31:1] == 31'd0);
`else
  assign w_early_out = 1'b0;
`endif

  // One shift-add multiply step: add the multiplicand when the current multiplier LSB is set.
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : 64'd0);

  // One restoring divide step on the 33-bit shifted partial remainder.
  assign w_rem_sh   = {r_rem, r_quot[31]};
  assign w_q_bit    = (w_rem_sh >= {1'b0, r_divisor});
  assign w_rem_diff = w_rem_sh[31:0] - r_divisor;

  assign w_raw_result = r_is_div ? {r_rem, r_quot} : r_acc;

  muldiv_signfix u_signfix (
    .i_data     (w_raw_result),
    .i_neg_full (~r_is_div & r_neg_q),
    .i_neg_hi   (r_is_div & r_neg_r),
    .i_neg_lo   (r_is_div & r_neg_q),
    .o_data     (w_fixed_result)
  );

  // Divide by zero reports the raw dividend and an all-ones quotient regardless of signedness.
  assign w_result = (r_is_div & r_divz) ? {r_rs_raw, 32'hFFFF_FFFF} : w_fixed_result;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    else        r_state <= w_next_state;
  end

  // Next-state logic; cancel wins over everything, including a start in IDLE.
  always_comb begin
    w_next_state = r_state;
    if (cancel) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_next_state = CALC;
        CALC:    if ((r_cnt == '0) || w_early_out) w_next_state = FIX;
        FIX:     w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Output decode from the current state.
  always_comb begin
    busy      = (r_state != IDLE);
    w_in_calc = (r_state == CALC);
    w_in_fix  = (r_state == FIX);
  end

  assign stall_req = busy & (start | mthi | mtlo | hilo_rd);

  // Operand latch at accept and per-iteration datapath update in CALC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_divz    <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rs_raw  <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
    end else if (w_accept) begin
      r_cnt     <= CNT_INIT;
      r_is_div  <= op[1];
      r_divz    <= op[1] & (rt_data == 32'd0);
      r_neg_q   <= w_signed & (rs_data[31] ^ rt_data[31]);
      r_neg_r   <= w_signed & op[1] & rs_data[31];
      r_rs_raw  <= rs_data;
      r_mcand   <= {32'd0, w_a_mag};
      r_mplier  <= w_b_mag;
      r_acc     <= '0;
      r_quot    <= w_a_mag;
      r_rem     <= '0;
      r_divisor <= w_b_mag;
    end else if (w_in_calc && !cancel) begin
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      if (r_is_div) begin
        r_rem  <= w_q_bit ? w_rem_diff : w_rem_sh[31:0];
        r_quot <= {r_quot[30:0], w_q_bit};
      end else begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= {r_mcand[62:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[31:1]};
      end
    end
  end

  // HI/LO: result write in FIX, otherwise MTHI/MTLO in IDLE unless a start claims the cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_in_fix && !cancel) begin
      r_hi <= w_result[63:32];
      r_lo <= w_result[31:0];
    end else if ((r_state == IDLE) && !start) begin
      if (mthi) r_hi <= rs_data;
      if (mtlo) r_lo <= rs_data;
    end
  end

  // Done pulses for exactly the cycle after HI/LO take a result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_done <= 1'b0;
    else        r_done <= w_in_fix & ~cancel;
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign done = r_done;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: self-checking bench for ex_muldiv. Expected HI/LO and
// latency come from a plain-arithmetic reference model; HI/LO contents
// between operations are tracked by the bench itself.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic        hilo_rd;
  logic        cancel;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_req;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  ex_muldiv dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .hilo_rd   (hilo_rd),
    .cancel    (cancel),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics plus the unit's divide-by-zero rule and latency.
  function automatic void model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] ehi, output logic [31:0] elo, output int elat);
    longint      sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] m;
    int          nb;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    elat = 33;
    ehi  = '0;
    elo  = '0;
    case (mop)
      OP_MULT:  begin p = 64'(sa * sb);                         ehi = p[63:32]; elo = p[31:0]; end
      OP_MULTU: begin p = 64'(longint'(a) * longint'(b));       ehi = p[63:32]; elo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          ehi = a;
          elo = 32'hFFFF_FFFF;
        end else if (mop == OP_DIV) begin
          q = sa / sb; r = sa % sb;
          elo = q[31:0]; ehi = r[31:0];
        end else begin
          q = longint'(a) / longint'(b); r = longint'(a) % longint'(b);
          elo = q[31:0]; ehi = r[31:0];
        end
      end
    endcase
`ifdef MULDIV_EARLY_OUT_EN
    if (!mop[1]) begin
      m  = (mop == OP_MULT && b[31]) ? 32'(0 - b) : b;
      nb = 1;
      for (int i = 0; i < 32; i++) if (m[i]) nb = i + 1;
      elat = nb + 1;
    end
`else
    m  = '0;
    nb = 0;
`endif
  endfunction

  // mode 0 plain, 1 mthi/mtlo with start, 2 pokes while busy, 3 hilo_rd stall from E5.
  task automatic run_op(input string tag, input logic [1:0] mop, input logic [31:0] a,
                        input logic [31:0] b, input int mode);
    logic [31:0] ehi, elo;
    int          elat, lat;
    model(mop, a, b, ehi, elo, elat);
    op = mop; rs_data = a; rt_data = b; start = 1'b1;
    if (mode == 1) begin mthi = 1'b1; mtlo = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check({tag, ".busy0"}, 64'(busy), 64'd1);
    if (mode == 1) begin
      check({tag, ".mthi_drop"}, 64'(hi), 64'(m_hi));
      check({tag, ".mtlo_drop"}, 64'(lo), 64'(m_lo));
    end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mode == 2 && k == 5) begin start = 1'b0; mthi = 1'b0; mtlo = 1'b0; end
      if (done) begin lat = k; break; end
      if (mode == 2 && k == 5) begin
        check({tag, ".busy_hi"}, 64'(hi), 64'(m_hi));
        check({tag, ".busy_lo"}, 64'(lo), 64'(m_lo));
      end
      if (mode == 3 && k >= 5) check({tag, ".stall"}, 64'(stall_req), 64'd1);
      if (mode == 2 && k == 4) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = OP_MULT; rs_data = ~a; rt_data = 32'd3;
        #1 check({tag, ".poke_stall"}, 64'(stall_req), 64'd1);
      end
      if (mode == 3 && k == 4) hilo_rd = 1'b1;
    end
    check({tag, ".latency"}, 64'(lat), 64'(elat));
    if (lat >= 0) begin
      check({tag, ".hi"}, 64'(hi), 64'(ehi));
      check({tag, ".lo"}, 64'(lo), 64'(elo));
      check({tag, ".busy_end"}, 64'(busy), 64'd0);
      if (mode == 3) check({tag, ".stall_end"}, 64'(stall_req), 64'd0);
      hilo_rd = 1'b0;
      @(negedge clk);
      check({tag, ".done_pulse"}, 64'(done), 64'd0);
    end
    hilo_rd = 1'b0;
    m_hi = ehi;
    m_lo = elo;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin : main
    bit done_seen;
    reset = 1'b0; start = 1'b0; op = OP_MULT; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0; hilo_rd = 1'b0; cancel = 1'b0;
    #12;
    check("rst.hi", 64'(hi), 64'd0);
    check("rst.lo", 64'(lo), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op("mult_neg3x5",    OP_MULT,  32'hFFFF_FFFD, 32'd5,         0);
    run_op("multu_max",      OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div_m7_2",       OP_DIV,   32'hFFFF_FFF9, 32'd2,         0);
    run_op("divu_7_0",       OP_DIVU,  32'd7,         32'd0,         0);
    run_op("div_m7_0",       OP_DIV,   32'hFFFF_FFF9, 32'd0,         0);
    run_op("div_ovf",        OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("multu_9x3",      OP_MULTU, 32'd9,         32'd3,         0);
    run_op("mult_x0",        OP_MULT,  32'h1234_5678, 32'd0,         0);
    run_op("divu_stall",     OP_DIVU,  32'd100,       32'd7,         3);

    // MTHI/MTLO in IDLE write on the next edge.
    rs_data = 32'hA5A5_A5A5; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0; m_hi = 32'hA5A5_A5A5;
    check("mthi", 64'(hi), 64'(m_hi));
    rs_data = 32'h5A5A_1234; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0; m_lo = 32'h5A5A_1234;
    check("mtlo", 64'(lo), 64'(m_lo));

    // Cancel mid-MULT: back to IDLE, HI/LO untouched, no done.
    op = OP_MULT; rs_data = 32'd1234; rt_data = 32'd5678; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel.busy", 64'(busy), 64'd0);
    done_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    check("cancel.no_done", 64'(done_seen), 64'd0);
    check("cancel.hi", 64'(hi), 64'(m_hi));
    check("cancel.lo", 64'(lo), 64'(m_lo));

    // Cancel together with start in IDLE: start ignored.
    start = 1'b1; cancel = 1'b1; op = OP_DIVU; rs_data = 32'd9; rt_data = 32'd2;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel_start.busy", 64'(busy), 64'd0);
    check("cancel_start.hi", 64'(hi), 64'(m_hi));

    // Start with MTHI/MTLO drops the moves; pokes while busy are ignored.
    run_op("mt_with_start", OP_MULTU, 32'd2,         32'd3,         1);
    run_op("poke_busy",     OP_DIV,   32'h7654_3210, 32'hFFFF_FF00, 2);

    // Asynchronous reset in the middle of a DIV.
    op = OP_DIV; rs_data = 32'hFFFF_0000; rt_data = 32'd37; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst.hi", 64'(hi), 64'd0);
    check("midrst.lo", 64'(lo), 64'd0);
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.done", 64'(done), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] rop;
      rop = 2'($urandom_range(0, 3));
      run_op($sformatf("rnd%0d", i), rop, pick(), pick(), (i % 5 == 4) ? 2 : ((i % 7 == 3) ? 1 : 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
